rand_gen_multi: RTL

//  Parametrised multi-channel random number generator: NUM_CH independent Galois LFSRs of WIDTH bits.

---
 rtl/rand_gen_pkg.sv | 32 +++
 rtl/rand_gen_multi_lfsr_ch.sv | 87 ++++++++
 rtl/rand_gen_multi.sv | 91 +++++++++
 3 files changed

// File: rtl/rand_gen_pkg.sv
// Shared register map, control-bit positions and Galois LFSR step helpers
// for the multi-channel random number generator.
package rand_gen_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_SEED  = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_FREE_RUN    = 1;
  localparam int CTRL_ADV_ON_READ = 2;
  localparam int CTRL_W           = 3;

  // Maximal-length feedback taps for the supported widths.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] value, input int width);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    v    = value & mask;
    return (v >> 1) ^ (v[0] ? lfsr_taps(width) : 32'd0);
  endfunction

endpackage

// File: rtl/rand_gen_multi_lfsr_ch.sv
// One generator channel: LFSR state, control and advance counter registers,
// advance decision and the registered advance pulse.
module rand_lfsr_ch
  import rand_gen_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sel,
  input  logic             i_read,
  input  logic             i_write,
  input  logic [1:0]       i_reg,
  input  logic [31:0]      i_writedata,
  input  logic             i_call_edge,
  output logic [31:0]      o_rdata,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_valid
);

  localparam logic [WIDTH-1:0] SEED_TRUNC = DEFAULT_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_RST   = (SEED_TRUNC == '0) ? WIDTH'(1) : SEED_TRUNC;

  logic [WIDTH-1:0]  r_lfsr;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_count;
  logic              r_valid;

  logic             w_seed_wr;
  logic             w_ctrl_wr;
  logic             w_count_wr;
  logic             w_data_rd;
  logic             w_advance;
  logic [WIDTH-1:0] w_seed_val;
  logic [WIDTH-1:0] w_next;
  logic             w_unused_wdata;

  assign w_seed_wr  = i_sel && i_write && (i_reg == REG_SEED);
  assign w_ctrl_wr  = i_sel && i_write && (i_reg == REG_CTRL);
  assign w_count_wr = i_sel && i_write && (i_reg == REG_COUNT);
  assign w_data_rd  = i_sel && i_read  && (i_reg == REG_DATA);

  // Any trigger yields at most one step per cycle; the OR collapses coincident triggers.
  assign w_advance = r_ctrl[CTRL_EN] &&
                     (r_ctrl[CTRL_FREE_RUN] || i_call_edge ||
                      (r_ctrl[CTRL_ADV_ON_READ] && w_data_rd));

  assign w_seed_val     = (i_writedata[WIDTH-1:0] == '0) ? WIDTH'(1) : i_writedata[WIDTH-1:0];
  assign w_next         = WIDTH'(lfsr_next(32'(r_lfsr), WIDTH));
  assign w_unused_wdata = ^i_writedata;

  // NOTE: state registers use non-blocking assignments so every register in the
  // block samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr  <= SEED_RST;
      r_ctrl  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_seed_wr)      r_lfsr <= w_seed_val;
      else if (w_advance) r_lfsr <= w_next;

      if (w_ctrl_wr) r_ctrl <= i_writedata[CTRL_W-1:0];

      if (w_seed_wr || w_count_wr) r_count <= '0;
      else if (w_advance)          r_count <= r_count + 32'd1;

      r_valid <= w_advance && !w_seed_wr;
    end
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_DATA, REG_SEED: o_rdata = 32'(r_lfsr);
      REG_CTRL:           o_rdata = 32'(r_ctrl);
      default:            o_rdata = r_count;
    endcase
  end

  assign o_lfsr  = r_lfsr;
  assign o_valid = r_valid;

endmodule

// File: rtl/rand_gen_multi.sv
// Multi-channel LFSR random generator with an Avalon-MM slave: address decode,
// registered read mux and a synchronised, edge-detected call_enable conduit.
module rand_gen_multi
  import rand_gen_pkg::*;
#(
  parameter  int          NUM_CH       = 4,
  parameter  int          WIDTH        = 32,
  parameter  logic [31:0] DEFAULT_SEED = 32'h0000_0001,
  localparam int          ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  input  logic                    call_enable,
  output logic [NUM_CH*WIDTH-1:0] rand_out,
  output logic [NUM_CH-1:0]       rand_valid
);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("rand_gen_multi: WIDTH must be 8, 16 or 32");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rand_gen_multi: NUM_CH must be within 1..16");
  end

  localparam int CH_IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [1:0]          r_call_sync;
  logic                r_call_prev;
  logic [31:0]         r_readdata;

  logic                w_call_edge;
  logic [CH_IDX_W-1:0] w_ch_idx;
  logic [1:0]          w_reg;
  logic [31:0]         w_ch_rdata [NUM_CH];
  logic [31:0]         w_rd_mux;

  // call_enable is asynchronous: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_call_sync <= '0;
      r_call_prev <= 1'b0;
    end else begin
      r_call_sync <= {r_call_sync[0], call_enable};
      r_call_prev <= r_call_sync[1];
    end
  end

  assign w_call_edge = r_call_sync[1] && !r_call_prev;
  assign w_reg       = avs_address[1:0];
  assign w_ch_idx    = CH_IDX_W'(avs_address >> 2);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rand_lfsr_ch #(
      .WIDTH       (WIDTH),
      .DEFAULT_SEED(DEFAULT_SEED)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_sel      (w_ch_idx == CH_IDX_W'(c)),
      .i_read     (avs_read),
      .i_write    (avs_write),
      .i_reg      (w_reg),
      .i_writedata(avs_writedata),
      .i_call_edge(w_call_edge),
      .o_rdata    (w_ch_rdata[c]),
      .o_lfsr     (rand_out[c*WIDTH +: WIDTH]),
      .o_valid    (rand_valid[c])
    );
  end

  // Channel indices with no instance fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_idx == CH_IDX_W'(c)) w_rd_mux = w_ch_rdata[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_readdata <= '0;
    else if (avs_read) r_readdata <= w_rd_mux;
  end

  assign avs_readdata = r_readdata;

endmodule
